// File: rtl/ks_prefix_pipe.sv
// ks_prefix_pipe
//   Pipelined Kogge-Stone prefix tree plus sum stage. It takes per-bit
//   propagate/generate vectors and a carry-in from the pg stage, resolves one
//   prefix level per pipeline stage and forms sum, carry-out and signed
//   overflow in the last stage's registers.
//
// Ports
//   i_clk, i_rst    clock (rising edge), asynchronous active-high reset
//   i_flush         synchronous flush, drops every in-flight operation
//   i_valid/o_ready upstream handshake (o_ready is low while flushing)
//   i_c0_1          carry-in
//   i_pk_1, i_gk_1  per-bit propagate / generate, WIDTH bits
//   o_valid/i_ready downstream handshake
//   o_sum           a+b+c0 modulo 2^WIDTH
//   o_cout          carry out of bit WIDTH-1
//   o_ovf           two's-complement overflow

// One prefix level at distance D. Positions with no partner at i-D combine
// with the carry-in as (G,P) = (c0,0). That combine is idempotent (it forces
// P to 0), so applying it at every level is the same as applying it once.
module ks_level #(
  parameter int WIDTH = 16,
  parameter int D     = 1
) (
  input  logic [WIDTH-1:0] g_i,
  input  logic [WIDTH-1:0] pg_i,
  input  logic             c0_i,
  output logic [WIDTH-1:0] g_o,
  output logic [WIDTH-1:0] pg_o
);
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (i >= D) begin : g_pair
      assign g_o[i]  = g_i[i] | (pg_i[i] & g_i[i-D]);
      assign pg_o[i] = pg_i[i] & pg_i[i-D];
    end else begin : g_cin
      assign g_o[i]  = g_i[i] | (pg_i[i] & c0_i);
      assign pg_o[i] = 1'b0;
    end
  end
endmodule

module ks_prefix_pipe #(
  parameter  int WIDTH = 16,
  localparam int LVL   = $clog2(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_c0_1,
  input  logic [WIDTH-1:0] i_pk_1,
  input  logic [WIDTH-1:0] i_gk_1,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf
);

  // Stage k inputs (_s) and combined level-k results (_d)
  logic [LVL:1][WIDTH-1:0] g_s, pg_s, p_s, g_d, pg_d;
  logic [LVL:1]            c0_s, vld_s, adv;

  // Registers between stages 1..LVL-1; stage LVL registers hold the result
  logic [LVL-1:1][WIDTH-1:0] g_q, pg_q, p_q;
  logic [LVL-1:1]            c0_q;
  logic [LVL:1]              vld_q;
  logic [WIDTH-1:0]          sum_q, sum_d;
  logic                      cout_q, cout_d, ovf_q, ovf_d;
  logic [WIDTH:0]            c;
  logic                      accept;

  // A stage advances when it is empty or its successor moves on, so bubbles
  // collapse and o_ready only falls once every stage holds an operation.
  always_comb begin
    adv = '0;
    adv[LVL] = ~vld_q[LVL] | i_ready;
    for (int k = LVL - 1; k >= 1; k--)
      adv[k] = ~vld_q[k] | adv[k+1];
  end

  assign o_ready = adv[1] & ~i_flush;
  assign accept  = i_valid & o_ready;

  for (genvar k = 1; k <= LVL; k++) begin : g_stage
    if (k == 1) begin : g_first
      assign g_s[k]   = i_gk_1;
      assign pg_s[k]  = i_pk_1;
      assign p_s[k]   = i_pk_1;
      assign c0_s[k]  = i_c0_1;
      assign vld_s[k] = accept;
    end else begin : g_next
      assign g_s[k]   = g_q[k-1];
      assign pg_s[k]  = pg_q[k-1];
      assign p_s[k]   = p_q[k-1];
      assign c0_s[k]  = c0_q[k-1];
      assign vld_s[k] = vld_q[k-1];
    end

    ks_level #(.WIDTH(WIDTH), .D(1 << (k - 1))) u_lvl (
      .g_i  (g_s[k]),
      .pg_i (pg_s[k]),
      .c0_i (c0_s[k]),
      .g_o  (g_d[k]),
      .pg_o (pg_d[k])
    );
  end

  // After LVL levels every group spans down to bit 0, but the topmost
  // positions never met the carry-in; folding c0 in here completes them
  // (a no-op for positions whose P is already 0).
  always_comb begin
    c    = '0;
    c[0] = c0_s[LVL];
    for (int i = 0; i < WIDTH; i++)
      c[i+1] = g_d[LVL][i] | (pg_d[LVL][i] & c0_s[LVL]);
    sum_d  = p_s[LVL] ^ c[WIDTH-1:0];
    cout_d = c[WIDTH];
    ovf_d  = c[WIDTH] ^ c[WIDTH-1];
  end

  // Valid bits: reset over flush over handshake
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vld_q <= '0;
    end else if (i_flush) begin
      vld_q <= '0;
    end else begin
      for (int k = 1; k <= LVL; k++)
        if (adv[k]) vld_q[k] <= vld_s[k];
    end
  end

  // Data only moves with a valid operation, so a stalled output holds.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      g_q    <= '0;
      pg_q   <= '0;
      p_q    <= '0;
      c0_q   <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      for (int k = 1; k <= LVL - 1; k++) begin
        if (adv[k] && vld_s[k]) begin
          g_q[k]  <= g_d[k];
          pg_q[k] <= pg_d[k];
          p_q[k]  <= p_s[k];
          c0_q[k] <= c0_s[k];
        end
      end
      if (adv[LVL] && vld_s[LVL]) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
        ovf_q  <= ovf_d;
      end
    end
  end

  assign o_valid = vld_q[LVL];
  assign o_sum   = sum_q;
  assign o_cout  = cout_q;
  assign o_ovf   = ovf_q;

endmodule

// File: tb/tb_ks_prefix_pipe.sv
module tb_ks_prefix_pipe;
  localparam int W = 16;
  localparam int L = 4;

  logic         i_clk = 1'b0, i_rst = 1'b1, i_flush = 1'b0;
  logic         i_valid = 1'b0, i_ready = 1'b1, i_c0_1 = 1'b0;
  logic [W-1:0] i_pk_1 = '0, i_gk_1 = '0;
  logic         o_ready, o_valid, o_cout, o_ovf;
  logic [W-1:0] o_sum;

  always #5 i_clk = ~i_clk;

  ks_prefix_pipe #(.WIDTH(W)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush),
    .i_valid(i_valid), .o_ready(o_ready), .i_c0_1(i_c0_1),
    .i_pk_1(i_pk_1), .i_gk_1(i_gk_1),
    .o_valid(o_valid), .i_ready(i_ready),
    .o_sum(o_sum), .o_cout(o_cout), .o_ovf(o_ovf)
  );

  typedef struct { logic [W-1:0] s; logic co; logic of; int acc; } exp_t;
  exp_t q[$];
  int errors = 0, checks = 0, cyc = 0, nout = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference from the operands themselves: a+b+c0 and sign-rule overflow
  function automatic logic [W+1:0] mdl(input logic [W-1:0] a, b, input logic c);
    logic [W:0] s;
    logic       ov;
    s  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    ov = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    return {ov, s};
  endfunction

  task automatic drive(input logic v, input logic [W-1:0] p, g, input logic c);
    i_valid = v; i_pk_1 = p; i_gk_1 = g; i_c0_1 = c;
  endtask

  // One cycle: check an outgoing transfer, record an incoming one, clock.
  task automatic step(input logic [W-1:0] es, input logic eco, eof, input bit lat);
    exp_t e, h;
    #1;
    if (o_valid && i_ready) begin
      if (q.size() == 0) chk("unexpected_out", {31'b0, o_valid}, 0);
      else begin
        h = q.pop_front();
        chk("sum", o_sum, h.s);
        chk("cout", o_cout, h.co);
        chk("ovf", o_ovf, h.of);
        if (lat) chk("latency", cyc - h.acc, L);
        nout++;
      end
    end
    if (i_valid && o_ready) begin
      e.s = es; e.co = eco; e.of = eof; e.acc = cyc;
      q.push_back(e);
    end
    @(posedge i_clk); cyc++; #1;
  endtask

  task automatic rop(input bit lat);
    logic [W-1:0] a, b;
    logic         c;
    logic [W+1:0] m;
    a = W'($urandom); b = W'($urandom); c = 1'($urandom);
    m = mdl(a, b, c);
    drive(1'b1, a ^ b, a & b, c);
    step(m[W-1:0], m[W], m[W+1], lat);
  endtask

  task automatic idle(input int n);
    drive(1'b0, '0, '0, 1'b0);
    for (int i = 0; i < n; i++) step('0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    int n0;
    logic [W-1:0] hs;
    logic hco, hof;
    bit have;

    // Reset state
    #3;
    chk("rst_valid", o_valid, 0);
    chk("rst_sum", o_sum, 0);
    chk("rst_cout", o_cout, 0);
    chk("rst_ovf", o_ovf, 0);
    #9 i_rst = 1'b0;
    @(posedge i_clk); #1;
    chk("rst_ready", o_ready, 1);

    // Directed arithmetic, one at a time, latency checked
    drive(1'b1, 16'hFFFE, 16'h0001, 1'b0); step(16'h0000, 1'b1, 1'b0, 1'b1); idle(6);
    drive(1'b1, 16'h7FFE, 16'h0001, 1'b0); step(16'h8000, 1'b0, 1'b1, 1'b1); idle(6);
    drive(1'b1, 16'h0000, 16'h0000, 1'b1); step(16'h0001, 1'b0, 1'b0, 1'b1); idle(6);
    // carry-in must reach the top bit: 0xFFFF+0+1
    drive(1'b1, 16'hFFFF, 16'h0000, 1'b1); step(16'h0000, 1'b1, 1'b0, 1'b1);
    // back-to-back: 0x8000+0x8000, then 0x00FF+0x0100+1
    drive(1'b1, 16'h0000, 16'h8000, 1'b0); step(16'h0000, 1'b1, 1'b1, 1'b1);
    drive(1'b1, 16'h01FF, 16'h0000, 1'b1); step(16'h0200, 1'b0, 1'b0, 1'b1);
    idle(6);
    chk("directed_drained", q.size(), 0);
    chk("directed_count", nout, 6);

    // Throughput: 1000 back-to-back random ops
    n0 = nout;
    for (int i = 0; i < 1000; i++) begin
      #1;
      chk("tput_ready", o_ready, 1);
      rop(1'b1);
    end
    idle(6);
    chk("tput_count", nout - n0, 1000);
    chk("tput_drained", q.size(), 0);

    // Backpressure: 10 cycles of i_ready=0 with continuous i_valid
    n0 = nout; i_ready = 1'b0; have = 0;
    for (int i = 0; i < 10; i++) begin
      rop(1'b0);
      if (o_valid) begin
        if (!have) begin hs = o_sum; hco = o_cout; hof = o_ovf; have = 1; end
        else begin
          chk("stall_sum", o_sum, hs);
          chk("stall_cout", o_cout, hco);
          chk("stall_ovf", o_ovf, hof);
        end
      end
    end
    chk("bp_accepts", q.size(), 4);
    chk("bp_ready", o_ready, 0);
    chk("bp_valid", o_valid, 1);
    i_ready = 1'b1;
    drive(1'b0, '0, '0, 1'b0);
    for (int i = 0; i < 6; i++) step('0, 1'b0, 1'b0, 1'b0);
    chk("bp_count", nout - n0, 4);
    chk("bp_drained", q.size(), 0);

    // Flush with 3 ops in flight and an op presented on the flush cycle
    rop(1'b1); rop(1'b1); rop(1'b1);
    drive(1'b1, 16'h1234, 16'h0000, 1'b0);
    i_flush = 1'b1;
    #1;
    chk("flush_ready", o_ready, 0);
    chk("flush_valid", o_valid, 0);
    step('0, 1'b0, 1'b0, 1'b1);
    q.delete();
    i_flush = 1'b0;
    chk("post_flush_valid", o_valid, 0);
    n0 = nout;
    // 0x00FF + 0x0100 + 1
    drive(1'b1, 16'h01FF, 16'h0000, 1'b1); step(16'h0200, 1'b0, 1'b0, 1'b1);
    idle(8);
    chk("flush_next_count", nout - n0, 1);
    chk("flush_drained", q.size(), 0);

    // Reset with the pipeline full and a result waiting at the output
    i_ready = 1'b0;
    for (int i = 0; i < 5; i++) rop(1'b0);
    chk("prerst_valid", o_valid, 1);
    #1 i_rst = 1'b1;
    #1;
    chk("midrst_valid", o_valid, 0);
    chk("midrst_sum", o_sum, 0);
    chk("midrst_cout", o_cout, 0);
    #1 i_rst = 1'b0;
    q.delete();
    i_ready = 1'b1;
    n0 = nout;
    idle(8);
    chk("postrst_count", nout - n0, 0);
    chk("postrst_ready", o_ready, 1);
    chk("postrst_valid", o_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
